// File: rtl/midi_rx_deserializer_if.sv
// MIDI receive bus between the deserializer and the CPU-side USART logic.
//   rd          : 1-clk pulse, pop FIFO head
//   err_clr     : 1-clk pulse, clear framing_err and overrun
//   rx_data     : FIFO head byte, valid while rx_ready=1
//   rx_ready    : FIFO not empty
//   rx_count    : bytes held in FIFO
//   framing_err : sticky, stop bit sampled 0
//   overrun     : sticky, byte arrived while FIFO full
interface midi_rx_deserializer_if #(
    parameter int FIFO_AW = 2
);
    logic               rd;
    logic               err_clr;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic [FIFO_AW:0]   rx_count;
    logic               framing_err;
    logic               overrun;

    modport slave (
        input  rd, err_clr,
        output rx_data, rx_ready, rx_count, framing_err, overrun
    );

    modport master (
        output rd, err_clr,
        input  rx_data, rx_ready, rx_count, framing_err, overrun
    );
endinterface

// File: rtl/midi_rx_deserializer.sv
// MIDI IN receive path: 8N1 serial at 31250 baud into a small byte FIFO.
// The raw line is synchronised, the start bit is validated at half a bit,
// every bit is taken by a 3-sample majority and good bytes are queued.
//   clk21m    : system clock
//   reset_n   : asynchronous active-low reset
//   pMidiRxD  : raw serial input, idle high, asynchronous to clk21m
//   bus       : CPU-side read/flag interface (slave modport)
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, waiting for a 1->0 edge on the synchronised line
// S_START | counting to mid start bit; a high sample there is a glitch
// S_DATA  | sampling 8 data bits LSB first, one per bit period
// S_STOP  | sampling the stop bit; high pushes the byte, low is framing err
// S_BREAK | line stuck low after a bad stop bit; wait for it to go high
module midi_rx_deserializer #(
    parameter int CLKS_PER_BIT = 687,
    parameter int FIFO_AW      = 2
) (
    input  logic                  clk21m,
    input  logic                  reset_n,
    input  logic                  pMidiRxD,
    midi_rx_deserializer_if.slave bus
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [CW-1:0]      HALF_C  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0]      LAST_C  = CW'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchroniser plus two history taps for the majority vote. All preset
    // to 1 so the line looks idle right after reset.
    logic rx_meta_q, rxs_q, rxs_h1_q, rxs_h2_q;
    logic sample_maj;

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            rxs_h1_q  <= 1'b1;
            rxs_h2_q  <= 1'b1;
        end else begin
            rx_meta_q <= pMidiRxD;
            rxs_q     <= rx_meta_q;
            rxs_h1_q  <= rxs_q;
            rxs_h2_q  <= rxs_h1_q;
        end
    end

    assign sample_maj = (rxs_q & rxs_h1_q) | (rxs_q & rxs_h2_q) | (rxs_h1_q & rxs_h2_q);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          push_q;
    logic [7:0]    push_data_q;
    logic          fe_q;

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            fe_q        <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // A framing error detected in the same cycle as err_clr wins,
            // because the set below is the later assignment.
            if (bus.err_clr) begin
                fe_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (!rxs_q && rxs_h1_q) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF_C) begin
                        cnt_q <= '0;
                        if (sample_maj) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == LAST_C) begin
                        cnt_q     <= '0;
                        shift_q   <= {sample_maj, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == LAST_C) begin
                        cnt_q <= '0;
                        if (sample_maj) begin
                            push_q      <= 1'b1;
                            push_data_q <= shift_q;
                            state_q     <= S_IDLE;
                        end else begin
                            fe_q    <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rxs_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Byte FIFO
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ov_q, ov_d;
    logic               fifo_full, fifo_empty, do_pop, do_push;

    always_comb begin
        fifo_full  = (count_q == DEPTH_C);
        fifo_empty = (count_q == '0);
        do_pop     = bus.rd && !fifo_empty;
        // When full, a coincident pop frees the slot the push needs.
        do_push    = push_q && (!fifo_full || do_pop);

        wr_ptr_d = do_push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (FIFO_AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (FIFO_AW+1)'(1);
        end

        ov_d = ov_q;
        if (bus.err_clr) begin
            ov_d = 1'b0;
        end
        if (push_q && !do_push) begin
            ov_d = 1'b1;
        end
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ov_q     <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ov_q     <= ov_d;
        end
    end

    assign bus.rx_data     = mem_q[rd_ptr_q];
    assign bus.rx_ready    = !fifo_empty;
    assign bus.rx_count    = count_q;
    assign bus.framing_err = fe_q;
    assign bus.overrun     = ov_q;

endmodule
